note_hit_scorer: RTL and testbench

- Downstream consumer of the per-lane note-matching stage.
- Takes each match event (match_enable pulse + match_time) and grades timing error against current song_time as PERFECT/GOOD/OK/MISS.
- Maintains combo counter, score multiplier and running score; feeds HUD/seven-segment display logic.
- One instance per lane; lane scores are summed elsewhere.

---
 rtl/note_hit_scorer_pkg.sv | 31 +++
 rtl/note_hit_scorer_if.sv | 27 ++
 rtl/note_grade_classifier.sv | 24 ++
 rtl/note_hit_scorer.sv | 133 +++++++++++++
 tb/tb_note_hit_scorer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/note_hit_scorer_pkg.sv
// Shared types and constants for the note hit scorer: grade encodings,
// point values, datapath widths and the grade-to-points lookup.
package note_score_pkg;

  localparam int SCORE_W = 24;
  localparam int COMBO_W = 10;
  localparam int TIME_W  = 18;
  localparam int MULT_W  = 3;
  localparam int PTS_W   = 7;

  typedef enum logic [1:0] {
    GRADE_MISS    = 2'd0,
    GRADE_OK      = 2'd1,
    GRADE_GOOD    = 2'd2,
    GRADE_PERFECT = 2'd3
  } grade_e;

  localparam logic [PTS_W-1:0] PTS_PERFECT = 7'd100;
  localparam logic [PTS_W-1:0] PTS_GOOD    = 7'd50;
  localparam logic [PTS_W-1:0] PTS_OK      = 7'd20;

  function automatic logic [PTS_W-1:0] grade_points(input grade_e g);
    case (g)
      GRADE_PERFECT: return PTS_PERFECT;
      GRADE_GOOD:    return PTS_GOOD;
      GRADE_OK:      return PTS_OK;
      default:       return '0;
    endcase
  endfunction

endpackage

// File: rtl/note_hit_scorer_if.sv
// Bundle of the lane scorer's match-event inputs and judgement/score outputs.
// The master side drives match events; the slave side is the scorer.
interface note_hit_scorer_if;
  import note_score_pkg::*;

  logic                song_clear;
  logic [TIME_W-1:0]   song_time;
  logic                match_enable;
  logic [TIME_W-1:0]   match_time;
  logic                judge_valid;
  grade_e              judge_grade;
  logic [COMBO_W-1:0]  combo;
  logic [MULT_W-1:0]   multiplier;
  logic [SCORE_W-1:0]  score;
  logic [COMBO_W-1:0]  max_combo;

  modport master (
    output song_clear, song_time, match_enable, match_time,
    input  judge_valid, judge_grade, combo, multiplier, score, max_combo
  );

  modport slave (
    input  song_clear, song_time, match_enable, match_time,
    output judge_valid, judge_grade, combo, multiplier, score, max_combo
  );

endinterface

// File: rtl/note_grade_classifier.sv
// Combinational timing-error grader: maps |error| and the invalid-note flag
// onto MISS/OK/GOOD/PERFECT using nested windows.
module note_grade_classifier
  import note_score_pkg::*;
#(
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6,
  parameter int OK_WIN      = 10
) (
  input  logic [TIME_W-1:0] err,
  input  logic              invalid,
  output grade_e            grade
);

  always_comb begin
    // Invalid notes always miss, even when the error happens to be zero.
    if (invalid)                         grade = GRADE_MISS;
    else if (err <= TIME_W'(PERFECT_WIN)) grade = GRADE_PERFECT;
    else if (err <= TIME_W'(GOOD_WIN))    grade = GRADE_GOOD;
    else if (err <= TIME_W'(OK_WIN))      grade = GRADE_OK;
    else                                  grade = GRADE_MISS;
  end

endmodule

// File: rtl/note_hit_scorer.sv
// Per-lane hit scorer: two-stage grade pipeline feeding combo, multiplier and
// saturating score. Define SCORER_MAX_COMBO_EN to add the best-combo tracker.
module note_hit_scorer
  import note_score_pkg::*;
#(
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6,
  parameter int OK_WIN      = 10,
  parameter int MULT_STEP   = 10,
  parameter int MULT_MAX    = 4
) (
  input logic              clk,
  input logic              rst_n,
  note_hit_scorer_if.slave bus
);

  localparam int ADD_W = PTS_W + MULT_W;

  logic                s1_valid_q, s1_valid_d;
  logic [TIME_W-1:0]   err_q, err_d;
  logic                invalid_q, invalid_d;
  logic                judge_valid_q, judge_valid_d;
  grade_e              judge_grade_q, judge_grade_d;
  grade_e              s2_grade;
  logic [COMBO_W-1:0]  combo_q, combo_d;
  logic [MULT_W-1:0]   mult_q, mult_d;
  logic [SCORE_W-1:0]  score_q, score_d;

  logic [COMBO_W-1:0]  next_combo;
  logic [COMBO_W-1:0]  tier;
  logic [ADD_W-1:0]    add;
  logic [SCORE_W:0]    sum;

  // Stage 1: capture the absolute timing error and the invalid-note flag.
  always_comb begin
    s1_valid_d = bus.match_enable & ~bus.song_clear;
    err_d      = (bus.song_time >= bus.match_time) ? bus.song_time - bus.match_time
                                                   : bus.match_time - bus.song_time;
    invalid_d  = (bus.match_time == '0);
  end

  note_grade_classifier #(
    .PERFECT_WIN (PERFECT_WIN),
    .GOOD_WIN    (GOOD_WIN),
    .OK_WIN      (OK_WIN)
  ) u_classifier (
    .err     (err_q),
    .invalid (invalid_q),
    .grade   (s2_grade)
  );

  // Stage 2: publish the grade; it holds until the next event.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    judge_valid_d = s1_valid_q & ~bus.song_clear;
    judge_grade_d = judge_grade_q;
    if (bus.song_clear)  judge_grade_d = GRADE_MISS;
    else if (s1_valid_q) judge_grade_d = s2_grade;
  end

  // Accumulators consume the grade during its judge_valid cycle, using the old multiplier.
  always_comb begin
    next_combo = (judge_grade_q == GRADE_MISS) ? '0 :
                 (combo_q == '1)               ? combo_q : combo_q + COMBO_W'(1);
    tier       = next_combo / COMBO_W'(MULT_STEP);
    add        = ADD_W'(grade_points(judge_grade_q)) * ADD_W'(mult_q);
    sum        = {1'b0, score_q} + (SCORE_W+1)'(add);

    combo_d = combo_q;
    mult_d  = mult_q;
    score_d = score_q;
    if (bus.song_clear) begin
      combo_d = '0;
      mult_d  = MULT_W'(1);
      score_d = '0;
    end else if (judge_valid_q) begin
      combo_d = next_combo;
      mult_d  = (tier >= COMBO_W'(MULT_MAX - 1)) ? MULT_W'(MULT_MAX)
                                                 : MULT_W'(tier + COMBO_W'(1));
      score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stage-1 data registers are reset as well, so no X ever reaches the grader.
      s1_valid_q    <= 1'b0;
      err_q         <= '0;
      invalid_q     <= 1'b0;
      judge_valid_q <= 1'b0;
      judge_grade_q <= GRADE_MISS;
      combo_q       <= '0;
      mult_q        <= MULT_W'(1);
      score_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q    <= s1_valid_d;
      err_q         <= err_d;
      invalid_q     <= invalid_d;
      judge_valid_q <= judge_valid_d;
      judge_grade_q <= judge_grade_d;
      combo_q       <= combo_d;
      mult_q        <= mult_d;
      score_q       <= score_d;
    end
  end

`ifdef SCORER_MAX_COMBO_EN
  logic [COMBO_W-1:0] max_combo_q, max_combo_d;

  always_comb begin
    max_combo_d = max_combo_q;
    if (bus.song_clear)                                    max_combo_d = '0;
    else if (judge_valid_q && (next_combo > max_combo_q)) max_combo_d = next_combo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_combo_q <= '0;
    else        max_combo_q <= max_combo_d;
  end

  assign bus.max_combo = max_combo_q;
`else
  assign bus.max_combo = '0;
`endif

  assign bus.judge_valid = judge_valid_q;
  assign bus.judge_grade = judge_grade_q;
  assign bus.combo       = combo_q;
  assign bus.multiplier  = mult_q;
  assign bus.score       = score_q;

endmodule

// File: tb/tb_note_hit_scorer.sv
// Self-checking bench for note_hit_scorer: grade table, directed multi-cycle
// sequences and random events scored against an event-level reference model.
module tb_note_hit_scorer;
  import note_score_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_hit_scorer_if bus ();

  note_hit_scorer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  typedef struct {
    int grade;
    int due;
  } pend_t;

  pend_t pend[$];
  int    cyc = 0;
  int    pulses = 0;
  longint m_score;
  int    m_combo, m_mult, m_max, last_grade;

  function automatic int ref_grade(input int st, input int mt);
    int e;
    e = (st > mt) ? st - mt : mt - st;
    if (mt == 0)  return 0;
    if (e <= 3)   return 3;
    if (e <= 6)   return 2;
    if (e <= 10)  return 1;
    return 0;
  endfunction

  function automatic int ref_points(input int g);
    case (g)
      3:       return 100;
      2:       return 50;
      1:       return 20;
      default: return 0;
    endcase
  endfunction

  function automatic void model_apply(input int g);
    m_score = m_score + longint'(ref_points(g) * m_mult);
    if (m_score > 64'd16777215) m_score = 64'd16777215;
    if (g == 0)             m_combo = 0;
    else if (m_combo < 1023) m_combo = m_combo + 1;
    m_mult = 1 + m_combo / 10;
    if (m_mult > 4) m_mult = 4;
    if (m_combo > m_max) m_max = m_combo;
  endfunction

  function automatic void model_reset();
    m_score = 0;
    m_combo = 0;
    m_mult = 1;
    m_max = 0;
    last_grade = 0;
    pend.delete();
  endfunction

  function automatic int exp_max();
`ifdef SCORER_MAX_COMBO_EN
    return m_max;
`else
    return 0;
`endif
  endfunction

  task automatic sample();
    bit    exp_v;
    pend_t p;
    exp_v = (pend.size() > 0) && (pend[0].due == cyc);
    check("judge_valid", 32'(bus.judge_valid), 32'(exp_v));
    check("score",       32'(bus.score),       32'(m_score));
    check("combo",       32'(bus.combo),       32'(m_combo));
    check("multiplier",  32'(bus.multiplier),  32'(m_mult));
    check("max_combo",   32'(bus.max_combo),   32'(exp_max()));
    if (bus.judge_valid) pulses++;
    if (exp_v) begin
      p = pend.pop_front();
      last_grade = p.grade;
      model_apply(p.grade);
    end
    check("judge_grade", 32'(bus.judge_grade), 32'(last_grade));
  endtask

  // Drive one cycle of inputs, then sample just after the following edge.
  task automatic step(input bit en, input int st, input int mt, input bit clr);
    bus.match_enable = en;
    bus.song_time    = 18'(st);
    bus.match_time   = 18'(mt);
    bus.song_clear   = clr;
    if (clr) model_reset();
    else if (en) pend.push_back('{grade: ref_grade(st, mt), due: cyc + 2});
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  typedef struct {
    int st;
    int mt;
    int g;
  } vec_t;

  vec_t tab[14];

  initial begin
    tab = '{'{500, 498, 3}, '{500, 505, 2}, '{500, 495, 2}, '{500, 509, 1},
            '{500, 491, 1}, '{500, 511, 0}, '{500, 489, 0}, '{0, 0, 0},
            '{10, 13, 3},   '{10, 16, 2},   '{10, 20, 1},   '{20, 9, 0},
            '{700, 0, 0},   '{1, 4, 3}};

    bus.song_clear   = 1'b0;
    bus.song_time    = '0;
    bus.match_enable = 1'b0;
    bus.match_time   = '0;
    model_reset();

    #12;
    sample();
    #10 rst_n = 1'b1;
    #2;

    // Grade table: isolated events, grade checked on the pulse cycle.
    for (int i = 0; i < 14; i++) begin
      step(1'b1, tab[i].st, tab[i].mt, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      check($sformatf("tab%0d_grade", i), 32'(bus.judge_grade), 32'(tab[i].g));
      check($sformatf("tab%0d_pulse", i), 32'(bus.judge_valid), 32'd1);
      step(1'b0, 0, 0, 1'b0);
      if (i == 0) begin
        check("first_score", 32'(bus.score), 32'd100);
        check("first_combo", 32'(bus.combo), 32'd1);
        check("first_mult",  32'(bus.multiplier), 32'd1);
      end
    end

    // Multiplier steps: 10 PERFECTs -> x2, the 11th earns 200, long run caps at x4.
    step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1000, 1000, 1'b0);
    idle(3);
    check("mult_after_10", 32'(bus.multiplier), 32'd2);
    check("score_after_10", 32'(bus.score), 32'd1000);
    step(1'b1, 1000, 1001, 1'b0);
    idle(3);
    check("score_after_11", 32'(bus.score), 32'd1200);
    for (int i = 0; i < 35; i++) step(1'b1, 1000, 999, 1'b0);
    idle(3);
    check("mult_cap", 32'(bus.multiplier), 32'd4);
    check("combo_46", 32'(bus.combo), 32'd46);

    // Back-to-back events, then a burst flushed by song_clear.
    step(1'b0, 0, 0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 300, 300, 1'b0);
    idle(3);
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_combo", 32'(bus.combo), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 300, 302, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    pulses = 0;
    idle(3);
    check("flush_pulses", 32'(pulses), 32'd0);
    check("flush_score", 32'(bus.score), 32'd0);
    check("flush_mult", 32'(bus.multiplier), 32'd1);

    // song_clear wins over a coincident match_enable.
    pulses = 0;
    step(1'b1, 500, 500, 1'b1);
    idle(3);
    check("clear_beats_enable", 32'(pulses), 32'd0);

    // Asynchronous reset with an event in flight.
    step(1'b1, 600, 601, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(bus.judge_valid), 32'd0);
    check("rst_mult",  32'(bus.multiplier), 32'd1);
    pulses = 0;
    @(posedge clk);
    #1;
    cyc++;
    sample();
    #2 rst_n = 1'b1;
    idle(3);
    check("rst_no_pulse", 32'(pulses), 32'd0);

    // Best combo: 12 hits, a MISS, then 3 hits.
    step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 400, 400, 1'b0);
    step(1'b1, 400, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 400, 402, 1'b0);
    idle(3);
    check("combo_after_miss", 32'(bus.combo), 32'd3);
`ifdef SCORER_MAX_COMBO_EN
    check("max_combo_12", 32'(bus.max_combo), 32'd12);
`else
    check("max_combo_off", 32'(bus.max_combo), 32'd0);
`endif

    // Random traffic against the model.
    step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      int st, mt;
      bit en, clr;
      st  = int'($urandom_range(20, 5000));
      mt  = ($urandom_range(0, 15) == 0) ? 0 : st + int'($urandom_range(0, 26)) - 13;
      en  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 149) == 0);
      step(en, st, mt, clr);
    end
    idle(3);

    // Long PERFECT run drives score and combo into saturation.
    step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 42000; i++) step(1'b1, 800, 801, 1'b0);
    idle(3);
    check("score_saturated", 32'(bus.score), 32'd16777215);
    check("combo_saturated", 32'(bus.combo), 32'd1023);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
